// File: rtl/sorted_stream_out.sv
// Snapshot of the sorter's result streamed out one element per valid/ready handshake.
// Build option SORTED_STREAM_DESCENDING_EN streams largest-first instead of smallest-first.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a rising edge on sort_ready; outputs quiet
// STREAM | presenting buffer[index]; advancing on each handshake
module sorted_stream_out #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sorted_array [N],
    input  logic         sort_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         overrun
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

`ifdef SORTED_STREAM_DESCENDING_EN
    localparam logic [IW-1:0] FIRST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] END_IDX   = '0;
`else
    localparam logic [IW-1:0] FIRST_IDX = '0;
    localparam logic [IW-1:0] END_IDX   = IW'(N - 1);
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] index;
    logic          ready_q;
    logic          start;
    logic          streaming;
    logic          handshake;
    logic          at_end;
    logic [W-1:0]  buffer [N];

    // A held sort_ready level yields a single start; reset clears ready_q so a
    // level still high afterwards is seen as a fresh edge.
    assign start     = sort_ready & ~ready_q;
    assign streaming = (state == STREAM);
    assign handshake = streaming & out_ready;
    assign at_end    = (index == END_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (handshake && at_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = streaming;
        busy      = streaming;
        out_last  = streaming & at_end;
        out_data  = streaming ? buffer[index] : '0;
    end

    // A start arriving while streaming (including on the final handshake) is
    // discarded and only recorded in the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            index   <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < N; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            ready_q <= sort_ready;
            done    <= handshake & at_end;
            if (streaming && start) begin
                overrun <= 1'b1;
            end
            if (!streaming && start) begin
                index <= FIRST_IDX;
                for (int i = 0; i < N; i++) begin
                    buffer[i] <= sorted_array[i];
                end
            end else if (handshake && !at_end) begin
`ifdef SORTED_STREAM_DESCENDING_EN
                index <= index - 1'b1;
`else
                index <= index + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sorted_stream_out.sv
// Bench for sorted_stream_out: a cycle table for the basic stream, then
// queue-model-checked sequences (backpressure, overrun, level hold, reset) and random traffic.
module tb_sorted_stream_out;

    logic       clk;
    logic       reset;
    logic [7:0] sorted_array [8];
    logic       sort_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       overrun;

    sorted_stream_out #(.N(8), .W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .sorted_array (sorted_array),
        .sort_ready   (sort_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    typedef struct {
        logic sr;
        logic ordy;
        logic e_valid;
        int   e_pos;
        logic e_last;
        logic e_done;
    } vec_t;

    int         checks;
    int         failures;
    logic [7:0] basic [8];
    vec_t       tbl [12];

    // reference model: queue of elements still owed to the consumer
    logic [7:0] q [$];
    logic       m_over;
    logic       m_done;
    logic       m_prev;
    int         dut_hs;
    int         dut_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_elem(input int pos);
`ifdef SORTED_STREAM_DESCENDING_EN
        return basic[7 - pos];
`else
        return basic[pos];
`endif
    endfunction

    task automatic model_load();
        for (int k = 0; k < 8; k++) begin
`ifdef SORTED_STREAM_DESCENDING_EN
            q.push_back(sorted_array[7 - k]);
`else
            q.push_back(sorted_array[k]);
`endif
        end
    endtask

    // Apply inputs for the next edge, advance the model, then check after the edge.
    task automatic cyc(input logic sr, input logic ordy, input logic rst);
        logic st;
        logic hs;
        logic was_empty;
        sort_ready = sr;
        out_ready  = ordy;
        reset      = rst;
        if (!rst && out_valid && ordy) dut_hs++;
        if (rst) begin
            q.delete();
            m_over = 1'b0;
            m_done = 1'b0;
            m_prev = 1'b0;
        end else begin
            was_empty = (q.size() == 0);
            st = sr && !m_prev;
            hs = !was_empty && ordy;
            m_done = hs && (q.size() == 1);
            if (st && !was_empty) m_over = 1'b1;
            if (hs) void'(q.pop_front());
            if (st && was_empty) model_load();
            m_prev = sr;
        end
        @(posedge clk);
        #1;
        if (done) dut_done++;
        chk("valid", 32'(out_valid), 32'(q.size() != 0));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("last", 32'(out_last), 32'(q.size() == 1));
        chk("done", 32'(done), 32'(m_done));
        chk("overrun", 32'(overrun), 32'(m_over));
        if (q.size() != 0) chk("data", 32'(out_data), 32'(q[0]));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        dut_hs   = 0;
        dut_done = 0;
        m_over   = 1'b0;
        m_done   = 1'b0;
        m_prev   = 1'b0;
        basic[0] = 8'd3;   basic[1] = 8'd7;  basic[2] = 8'd9;  basic[3] = 8'd12;
        basic[4] = 8'd20;  basic[5] = 8'd33; basic[6] = 8'd41; basic[7] = 8'd255;
        for (int k = 0; k < 8; k++) sorted_array[k] = basic[k];

        for (int i = 0; i < 12; i++) begin
            tbl[i].sr      = (i < 10);
            tbl[i].ordy    = 1'b1;
            tbl[i].e_valid = (i < 8);
            tbl[i].e_pos   = i;
            tbl[i].e_last  = (i == 7);
            tbl[i].e_done  = (i == 8);
        end

        reset      = 1'b1;
        sort_ready = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // basic stream from the cycle table
        for (int i = 0; i < 12; i++) begin
            reset      = 1'b0;
            sort_ready = tbl[i].sr;
            out_ready  = tbl[i].ordy;
            @(posedge clk);
            #1;
            chk("tbl_valid", 32'(out_valid), 32'(tbl[i].e_valid));
            chk("tbl_last", 32'(out_last), 32'(tbl[i].e_last));
            chk("tbl_done", 32'(done), 32'(tbl[i].e_done));
            chk("tbl_overrun", 32'(overrun), 32'd0);
            if (tbl[i].e_valid) chk("tbl_data", 32'(out_data), 32'(exp_elem(tbl[i].e_pos)));
        end

        // backpressure: out_ready 1,0,0 repeating
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        dut_hs = 0; dut_done = 0;
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) cyc(1'b1, (i % 3) == 0, 1'b0);
        chk("bp_handshakes", 32'(dut_hs), 32'd8);
        chk("bp_done_pulses", 32'(dut_done), 32'd1);

        // overrun: fresh edge during stream
        cyc(1'b0, 1'b1, 1'b0);
        dut_hs = 0; dut_done = 0;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_handshakes", 32'(dut_hs), 32'd8);
        chk("ovr_done_pulses", 32'(dut_done), 32'd1);

        // level hold
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        dut_hs = 0; dut_done = 0;
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        chk("lvl_handshakes", 32'(dut_hs), 32'd8);
        chk("lvl_done_pulses", 32'(dut_done), 32'd1);

        // reset after the third handshake, sort_ready held high throughout
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("rm_data", 32'(out_data), 32'd0);
        chk("rm_valid", 32'(out_valid), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("rm_restart_data", 32'(out_data), 32'(exp_elem(0)));
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);

        // random traffic with changing sorter output
        cyc(1'b0, 1'b0, 1'b1);
        begin
            logic sr_r;
            sr_r = 1'b0;
            for (int i = 0; i < 600; i++) begin
                for (int k = 0; k < 8; k++) sorted_array[k] = 8'($urandom);
                if ($urandom_range(0, 7) == 0) sr_r = ~sr_r;
                cyc(sr_r, $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
